// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - test-pattern source behind video_timer: bars, grid, gradient, bouncing box
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int BOX_SIZE = 64,
    parameter int STEP     = 4
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic [10:0] counterX,
    input  logic [9:0]  counterY,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  mode,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] BOX_X_MAX = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  BOX_Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);
    localparam int          BAR_W     = H_ACTIVE / 8;

    logic [1:0]  r_mode_act;
    logic [10:0] r_box_x;
    logic [9:0]  r_box_y;
    logic        r_dx_neg;
    logic        r_dy_neg;
    logic        r_vs_prev;

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_de1;
    logic        r_hs1;
    logic        r_vs1;
    logic [2:0]  r_bar;
    logic        r_grid;
    logic        r_box;

    logic        w_frame_ev;
    logic [2:0]  w_bar;
    logic        w_grid;
    logic        w_box_hit;
    logic [11:0] w_x_end;
    logic [10:0] w_y_end;
    logic [11:0] w_x_step;
    logic [10:0] w_y_step;
    logic [23:0] w_rgb;

    assign w_frame_ev = vsync_in & ~r_vs_prev;
    assign w_x_end    = {1'b0, r_box_x} + 12'(BOX_SIZE);
    assign w_y_end    = {1'b0, r_box_y} + 11'(BOX_SIZE);
    assign w_x_step   = {1'b0, r_box_x} + 12'(STEP);
    assign w_y_step   = {1'b0, r_box_y} + 11'(STEP);

    // Bar index by comparator ladder; the lowest matching threshold wins.
    always_comb begin
        w_bar = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (int'(counterX) < (i + 1) * BAR_W) begin
                w_bar = 3'(i);
            end
        end
    end

    assign w_grid = (counterX[4:0] == 5'd0) || (counterY[4:0] == 5'd0) ||
                    (counterX == X_LAST) || (counterY == Y_LAST);

    assign w_box_hit = (counterX >= r_box_x) && ({1'b0, counterX} < w_x_end) &&
                       (counterY >= r_box_y) && ({1'b0, counterY} < w_y_end);

    // Frame state only moves on the vsync rising edge, which lies in blanking.
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            r_mode_act <= 2'd0;
            frame_cnt  <= 8'd0;
            r_box_x    <= 11'd0;
            r_box_y    <= 10'd0;
            r_dx_neg   <= 1'b0;
            r_dy_neg   <= 1'b0;
            r_vs_prev  <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_frame_ev) begin
                r_mode_act <= mode;
                frame_cnt  <= frame_cnt + 8'd1;

                if (!r_dx_neg && (w_x_step > {1'b0, BOX_X_MAX})) begin
                    r_box_x  <= BOX_X_MAX;
                    r_dx_neg <= 1'b1;
                end else if (r_dx_neg && (r_box_x < 11'(STEP))) begin
                    r_box_x  <= 11'd0;
                    r_dx_neg <= 1'b0;
                end else if (r_dx_neg) begin
                    r_box_x <= r_box_x - 11'(STEP);
                end else begin
                    r_box_x <= w_x_step[10:0];
                end

                if (!r_dy_neg && (w_y_step > {1'b0, BOX_Y_MAX})) begin
                    r_box_y  <= BOX_Y_MAX;
                    r_dy_neg <= 1'b1;
                end else if (r_dy_neg && (r_box_y < 10'(STEP))) begin
                    r_box_y  <= 10'd0;
                    r_dy_neg <= 1'b0;
                end else if (r_dy_neg) begin
                    r_box_y <= r_box_y - 10'(STEP);
                end else begin
                    r_box_y <= w_y_step[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            r_x    <= 11'd0;
            r_y    <= 10'd0;
            r_de1  <= 1'b0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_bar  <= 3'd0;
            r_grid <= 1'b0;
            r_box  <= 1'b0;
        end else begin
            r_x    <= counterX;
            r_y    <= counterY;
            r_de1  <= de_in;
            r_hs1  <= hsync_in;
            r_vs1  <= vsync_in;
            r_bar  <= w_bar;
            r_grid <= w_grid;
            r_box  <= w_box_hit;
        end
    end

    // Bar colours: red off for bars with bit1 set, green off for bit2, blue off for bit0.
    always_comb begin
        w_rgb = 24'h000000;
        case (r_mode_act)
            2'd0: w_rgb = {{8{~r_bar[1]}}, {8{~r_bar[2]}}, {8{~r_bar[0]}}};
            2'd1: w_rgb = r_grid ? 24'hFFFFFF : 24'h000000;
            2'd2: w_rgb = {r_x[10:3], r_y[9:2], frame_cnt};
            default: w_rgb = r_box ? 24'hFFFFFF : 24'h000040;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            r         <= 8'd0;
            g         <= 8'd0;
            b         <= 8'd0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            {r, g, b} <= r_de1 ? w_rgb : 24'h000000;
            de_out    <= r_de1;
            hsync_out <= r_hs1;
            vsync_out <= r_vs1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen against a behavioural model
module tb_video_pattern_gen;

    logic        clk_pix = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] counterX = 11'd0;
    logic [9:0]  counterY = 10'd0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  r, g, b;
    logic        de_out, hsync_out, vsync_out;
    logic [7:0]  frame_cnt;

    video_pattern_gen dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .counterX(counterX), .counterY(counterY),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode),
        .r(r), .g(g), .b(b), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .frame_cnt(frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic        rst;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
        logic [7:0]  fc;
    } item_t;

    item_t scb[$];
    item_t it_old, it_new;
    int    n_checks = 0;
    int    n_pass = 0;

    // Reference model state: what the frame looks like after the last frame event.
    int m_mode = 0, m_fc = 0, bx = 0, by = 0;
    bit dxn = 0, dyn = 0, m_vs_prev = 0;
    logic [23:0] bar_col [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] model_pix(int x, int y);
        case (m_mode)
            0: return bar_col[(x / 160 > 7) ? 7 : x / 160];
            1: return ((x % 32 == 0) || (y % 32 == 0) || x == 1279 || y == 719) ? 24'hFFFFFF : 24'h0;
            2: return {8'(x / 8), 8'(y / 4), 8'(m_fc)};
            default: return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFFFFFF : 24'h000040;
        endcase
    endfunction

    task automatic frame_event();
        m_mode = int'(mode);
        m_fc = (m_fc + 1) % 256;
        if (!dxn && bx + 4 > 1216) begin bx = 1216; dxn = 1; end
        else if (dxn && bx < 4) begin bx = 0; dxn = 0; end
        else bx = dxn ? bx - 4 : bx + 4;
        if (!dyn && by + 4 > 656) begin by = 656; dyn = 1; end
        else if (dyn && by < 4) begin by = 0; dyn = 0; end
        else by = dyn ? by - 4 : by + 4;
    endtask

    task automatic step(input logic rs, input int x, input int y, input logic de,
                        input logic hs, input logic vs);
        item_t it;
        @(negedge clk_pix);
        rst_n = rs; counterX = 11'(x); counterY = 10'(y);
        de_in = de; hsync_in = hs; vsync_in = vs;
        it.rst = rs; it.de = de; it.hs = hs; it.vs = vs;
        it.pix = de ? model_pix(x, y) : 24'h0;
        if (!rs) begin
            m_mode = 0; m_fc = 0; bx = 0; by = 0; dxn = 0; dyn = 0; m_vs_prev = 0;
        end else begin
            if (vs && !m_vs_prev) frame_event();
            m_vs_prev = vs;
        end
        it.fc = 8'(m_fc);
        scb.push_back(it);
    endtask

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
    endtask

    // Monitor: the entry two edges back drives pixels/syncs, the newest entry gives frame_cnt.
    always @(posedge clk_pix) begin
        #1;
        if (scb.size() >= 2) begin
            it_old = scb[0];
            it_new = scb[1];
            if (!it_new.rst || !it_old.rst) begin
                chk("sync", {21'd0, de_out, hsync_out, vsync_out}, 24'd0);
                chk("pix", {r, g, b}, 24'd0);
            end else begin
                chk("sync", {21'd0, de_out, hsync_out, vsync_out},
                    {21'd0, it_old.de, it_old.hs, it_old.vs});
                chk("pix", {r, g, b}, it_old.pix);
            end
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, it_new.fc});
            void'(scb.pop_front());
        end
    end

    function automatic int clx(int v);
        return (v < 0) ? 0 : (v > 1279) ? 1279 : v;
    endfunction

    function automatic int cly(int v);
        return (v < 0) ? 0 : (v > 719) ? 719 : v;
    endfunction

    task automatic frame(input int vlen, input int npix, input bit rnd_mode);
        repeat (2) step(1, 1300, 725, 0, 1, 0);
        repeat (vlen) step(1, 1300, 725, 0, 0, 1);
        repeat (2) step(1, 1300, 725, 0, 0, 0);
        for (int i = 0; i < npix; i++) begin
            if (rnd_mode && $urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 7) == 0)
                step(1, int'($urandom_range(1280, 1649)), int'($urandom_range(0, 749)), 0, 1, 0);
            else
                step(1, int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1, 0, 0);
        end
    endtask

    task automatic box_probes();
        int offs [0:3] = '{-1, 0, 63, 64};
        for (int i = 0; i < 4; i++) begin
            step(1, clx(bx + offs[i]), cly(by + 10), 1, 0, 0);
            step(1, clx(bx + 10), cly(by + offs[i]), 1, 0, 0);
        end
    endtask

    initial begin
        bit vs_r;
        // Reset held while the timer keeps running.
        for (int i = 0; i < 20; i++) begin
            vs_r = 1'($urandom);
            step(0, int'($urandom_range(0, 1649)), int'($urandom_range(0, 749)),
                 vs_r ? 1'b0 : 1'($urandom), 1'($urandom), vs_r);
        end
        for (int i = 0; i < 6; i++)
            step(1, int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1, 0, 0);

        // Colour bars, line y=10 edges.
        mode = 2'd0;
        frame(4, 20, 0);
        step(1, 0, 10, 1, 0, 0);
        step(1, 159, 10, 1, 0, 0);
        step(1, 160, 10, 1, 0, 0);
        step(1, 1279, 10, 1, 0, 0);
        step(1, 1300, 10, 0, 1, 0);

        // Mode switch mid-frame only takes effect at the next frame event.
        frame(4, 10, 0);
        mode = 2'd2;
        for (int i = 0; i < 10; i++) step(1, int'($urandom_range(0, 1279)), 100, 1, 0, 0);
        frame(4, 0, 0);
        step(1, 800, 400, 1, 0, 0);
        frame(4, 20, 0);

        // Grid lines and last row/column.
        mode = 2'd1;
        frame(4, 20, 0);
        step(1, 0, 5, 1, 0, 0);
        step(1, 31, 5, 1, 0, 0);
        step(1, 32, 5, 1, 0, 0);
        step(1, 1279, 5, 1, 0, 0);
        step(1, 5, 31, 1, 0, 0);
        step(1, 5, 719, 1, 0, 0);

        // Bouncing box over enough frames to hit both walls and wrap frame_cnt.
        mode = 2'd3;
        for (int f = 0; f < 340; f++) begin
            frame(3, 2, 0);
            box_probes();
        end

        // Reset in the middle of active video.
        step(1, 600, 300, 1, 0, 0);
        repeat (5) step(0, 600, 300, 1, 0, 0);
        step(1, 600, 300, 1, 0, 0);
        frame(3, 4, 0);
        box_probes();

        // vsync held high for a long time counts once.
        frame(200, 10, 0);

        for (int f = 0; f < 40; f++) begin
            mode = 2'($urandom);
            frame(int'($urandom_range(1, 5)), 30, 1);
        end

        repeat (3) step(1, 1300, 725, 0, 0, 0);
        @(posedge clk_pix);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
